// File: rtl/axi4lite_regbank_slave.sv
// axi4lite_regbank_slave: parametrised AXI4-Lite register bank with byte strobes, read-only mask and SLVERR on out-of-range
module axi4lite_regbank_slave #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] READONLY_MASK = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(NB);
    localparam int IW = ADDR_WIDTH - BSHIFT;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  aw_held, w_held;
    logic [IW-1:0]         aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]         w_strb;
    logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [IW-1:0]         wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, rd_word;
    logic [NB-1:0]         wr_strb;
    logic                  unused_addr;

    assign s_axi_awready = !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = !w_held && !s_axi_bvalid;
    assign s_axi_arready = !s_axi_rvalid;
    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    // A buffer counts as full on the edge it is being filled, so a same-cycle AW+W commits at once
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_idx  = aw_held ? aw_idx : s_axi_awaddr[ADDR_WIDTH-1:BSHIFT];
    assign wr_data = w_held ? w_data : s_axi_wdata;
    assign wr_strb = w_held ? w_strb : s_axi_wstrb;
    assign wr_ok   = 32'(wr_idx) < NUM_REGS;
    assign rd_idx  = s_axi_araddr[ADDR_WIDTH-1:BSHIFT];
    assign rd_ok   = 32'(rd_idx) < NUM_REGS;
    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    // Read mux; out-of-range words read as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (32'(rd_idx) == i) rd_word = regs[i];
    end

    // AW/W buffering, strobed register commit and B channel
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_ok ? 2'b00 : 2'b10;
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < NB; b++)
                    if (32'(wr_idx) == i && !READONLY_MASK[i] && wr_strb[b])
                        regs[i][8*b +: 8] <= wr_data[8*b +: 8];
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:BSHIFT];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
        end
    end

    // R channel: capture data on AR handshake, hold until rready
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_word;
            s_axi_rresp  <= rd_ok ? 2'b00 : 2'b10;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end
endmodule
